// File: rtl/cfg_bus_master.sv
// Single-outstanding command master for a homogeneous array of config register slaves.
// Latency: strobe 1 cycle after accept, response 2+RD_LAT cycles after accept (writes 2 when responded).
// Backpressure: req_ready only in IDLE; response is held stable until rsp_ready.
// Optional feature macro CFG_BUS_MASTER_WR_RSP_EN: when defined, writes also return a response.
module cfg_bus_master #(
    parameter int NUM_SLAVES = 4,
    parameter int SEL_W      = 2,
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int RD_LAT     = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [SEL_W+ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]            req_wdata,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic [NUM_SLAVES-1:0]        io_wr_en,
    output logic [NUM_SLAVES-1:0]        io_rd_en,
    output logic [ADDR_W-1:0]            io_address,
    output logic [DATA_W-1:0]            io_write_data,
    input  logic [NUM_SLAVES*DATA_W-1:0] io_read_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // One extra bit so the range test is meaningful even when every select value is populated.
    localparam logic [SEL_W:0] NUM_SEL  = (SEL_W+1)'(NUM_SLAVES);
    // WAIT counts down to zero; the last WAIT cycle is the sample cycle.
    localparam logic [2:0]     LAT_LOAD = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

`ifdef CFG_BUS_MASTER_WR_RSP_EN
    localparam bit WR_RSP = 1'b1;
`else
    localparam bit WR_RSP = 1'b0;
`endif

    state_t              state;
    logic                wr_q;
    logic [SEL_W-1:0]    sel_q;
    logic [2:0]          cnt;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic                sel_ok;
    logic [DATA_W-1:0]   rd_mux;

    assign sel_ok    = ({1'b0, sel_q} < NUM_SEL);
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // Read-data select from the latched index; out-of-range selects yield zero.
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (sel_q == SEL_W'(k)) begin
                rd_mux = io_read_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Strobes decoded only from registered state and latched select, so at most one bit is high.
    always_comb begin
        io_wr_en = '0;
        io_rd_en = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (state == ISSUE && sel_q == SEL_W'(k)) begin
                io_wr_en[k] = wr_q;
                io_rd_en[k] = ~wr_q;
            end
        end
    end

    // Request latch, read-latency countdown and response capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            wr_q          <= 1'b0;
            sel_q         <= '0;
            io_address    <= '0;
            io_write_data <= '0;
            cnt           <= '0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr_q          <= req_write;
                        sel_q         <= req_addr[SEL_W+ADDR_W-1 -: SEL_W];
                        io_address    <= req_addr[ADDR_W-1:0];
                        io_write_data <= req_wdata;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (wr_q) begin
                        if (WR_RSP) begin
                            rdata_q <= '0;
                            err_q   <= ~sel_ok;
                            state   <= RESP;
                        end else begin
                            state   <= IDLE;
                        end
                    end else if (RD_LAT == 0) begin
                        rdata_q <= rd_mux;
                        err_q   <= ~sel_ok;
                        state   <= RESP;
                    end else begin
                        cnt   <= LAT_LOAD;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 3'd0) begin
                        rdata_q <= rd_mux;
                        err_q   <= ~sel_ok;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_bus_master.sv
// Self-checking bench for cfg_bus_master with a 3-slave group (one select value unpopulated).
// Expected timing and data come from a transaction-level model of the request/response protocol.
// Slave read data is re-randomized every cycle so only the sample-cycle value can match.
module tb_cfg_bus_master;

    localparam int NS  = 3;
    localparam int LAT = 1;
`ifdef CFG_BUS_MASTER_WR_RSP_EN
    localparam bit WR_RSP = 1'b1;
`else
    localparam bit WR_RSP = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [5:0]    req_addr = '0;
    logic [7:0]    req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [7:0]    rsp_rdata;
    logic          rsp_err;
    logic [NS-1:0] io_wr_en;
    logic [NS-1:0] io_rd_en;
    logic [3:0]    io_address;
    logic [7:0]    io_write_data;
    logic [NS*8-1:0] io_read_data = '0;

    int checks = 0;
    int errors = 0;

    // Optional follow-up request presented while the current one is in flight.
    bit         nxt_en = 1'b0;
    logic       nxt_wr;
    logic [5:0] nxt_addr;
    logic [7:0] nxt_wd;
    // Optional forced value for the selected slave in the sample cycle.
    bit         pin_en = 1'b0;
    logic [7:0] pin_val;

    cfg_bus_master #(
        .NUM_SLAVES(NS), .SEL_W(2), .ADDR_W(4), .DATA_W(8), .RD_LAT(LAT)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .io_wr_en(io_wr_en), .io_rd_en(io_rd_en), .io_address(io_address),
        .io_write_data(io_write_data), .io_read_data(io_read_data)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One complete transaction checked cycle by cycle against the protocol timing.
    task automatic run_txn(input logic wr, input logic [5:0] addr, input logic [7:0] wd, input int hold);
        int         s;
        logic       exp_err;
        logic [NS-1:0] exp_stb;
        logic [7:0] exp_data;
        int         ncyc;
        s        = int'(addr[5:4]);
        exp_err  = (s >= NS);
        exp_stb  = exp_err ? '0 : (NS'(1) << s);
        exp_data = 8'h00;

        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL idle_ready got %b want 1 addr %h", req_ready, addr);
        end
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        step();
        if (nxt_en) begin
            req_write = nxt_wr; req_addr = nxt_addr; req_wdata = nxt_wd; nxt_en = 1'b0;
        end else begin
            req_valid = 1'b0;
        end

        ncyc = wr ? 1 : LAT + 1;
        for (int k = 0; k < ncyc; k++) begin
            io_read_data = (NS*8)'($urandom);
            if (!wr && k == LAT && !exp_err) begin
                if (pin_en) io_read_data[s*8 +: 8] = pin_val;
                exp_data = io_read_data[s*8 +: 8];
            end
            checks++;
            if (io_wr_en !== ((k == 0 && wr) ? exp_stb : '0)) begin
                errors++; $display("FAIL wr_en cyc %0d got %b want %b", k, io_wr_en, (k == 0 && wr) ? exp_stb : '0);
            end
            checks++;
            if (io_rd_en !== ((k == 0 && !wr) ? exp_stb : '0)) begin
                errors++; $display("FAIL rd_en cyc %0d got %b want %b", k, io_rd_en, (k == 0 && !wr) ? exp_stb : '0);
            end
            checks++;
            if (io_address !== addr[3:0] || io_write_data !== wd) begin
                errors++; $display("FAIL io_bus got %h/%h want %h/%h", io_address, io_write_data, addr[3:0], wd);
            end
            checks++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
                errors++; $display("FAIL busy_flags got rdy %b vld %b want 0 0", req_ready, rsp_valid);
            end
            step();
        end

        if (!wr || WR_RSP) begin
            for (int h = 0; h <= hold; h++) begin
                io_read_data = (NS*8)'($urandom);
                checks++;
                if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
                    errors++; $display("FAIL rsp_phase got vld %b rdy %b want 1 0", rsp_valid, req_ready);
                end
                checks++;
                if (rsp_rdata !== exp_data || rsp_err !== exp_err) begin
                    errors++; $display("FAIL rsp_data got %h err %b want %h err %b", rsp_rdata, rsp_err, exp_data, exp_err);
                end
                checks++;
                if (io_wr_en !== '0 || io_rd_en !== '0 || io_address !== addr[3:0]) begin
                    errors++; $display("FAIL rsp_quiet got %b %b %h want 0 0 %h", io_wr_en, io_rd_en, io_address, addr[3:0]);
                end
                if (h == hold) rsp_ready = 1'b1;
                step();
            end
            rsp_ready = 1'b0;
        end
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || io_wr_en !== '0 || io_rd_en !== '0) begin
            errors++; $display("FAIL back_idle got vld %b rdy %b wr %b rd %b want 0 1 0 0", rsp_valid, req_ready, io_wr_en, io_rd_en);
        end
    endtask

    task automatic test_reset();
        step(); step();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 8'h00 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL reset_rsp got rdy %b vld %b data %h err %b", req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        checks++;
        if (io_wr_en !== '0 || io_rd_en !== '0 || io_address !== 4'h0 || io_write_data !== 8'h00) begin
            errors++; $display("FAIL reset_io got %b %b %h %h want zeros", io_wr_en, io_rd_en, io_address, io_write_data);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_write();
        run_txn(1'b1, 6'h25, 8'hA5, 0);
        run_txn(1'b1, 6'h0C, 8'h5A, 2);
    endtask

    task automatic test_read();
        pin_en = 1'b1; pin_val = 8'h3C;
        run_txn(1'b0, 6'h13, 8'h00, 0);
        pin_en = 1'b0;
        run_txn(1'b0, 6'h2E, 8'h77, 1);
    endtask

    task automatic test_error();
        run_txn(1'b0, 6'h3F, 8'h00, 0);
        run_txn(1'b1, 6'h31, 8'hFF, 1);
    endtask

    task automatic test_back_to_back();
        nxt_en = 1'b1; nxt_wr = 1'b0; nxt_addr = 6'h21; nxt_wd = 8'h99;
        run_txn(1'b0, 6'h13, 8'h00, 5);
        run_txn(1'b0, 6'h21, 8'h99, 0);
        nxt_en = 1'b1; nxt_wr = 1'b1; nxt_addr = 6'h07; nxt_wd = 8'h42;
        run_txn(1'b1, 6'h1A, 8'hC3, 0);
        run_txn(1'b1, 6'h07, 8'h42, 0);
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 6'h11; req_wdata = 8'h00;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < LAT; i++) step();
        reset = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || io_rd_en !== '0 || req_ready !== 1'b1 || io_address !== 4'h0) begin
            errors++; $display("FAIL reset_mid got vld %b rd %b rdy %b addr %h", rsp_valid, io_rd_en, req_ready, io_address);
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rsp_valid !== 1'b0 || io_rd_en !== '0 || io_wr_en !== '0 || req_ready !== 1'b1) begin
                errors++; $display("FAIL after_reset cyc %0d got vld %b rd %b wr %b rdy %b", i, rsp_valid, io_rd_en, io_wr_en, req_ready);
            end
            step();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            run_txn(1'($urandom), 6'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_error();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfg_bus_master.md
# cfg_bus_master

Upstream command stage for the configuration slave array: accepts one read/write request at a time on a valid/ready channel and decodes its upper address bits to select one of NUM_SLAVES register slaves. It drives that slave's one-cycle wr_en/rd_en strobe with address and write data, samples the selected read_data after a fixed read latency, and returns a response on a second valid/ready channel. One instance feeds one homogeneous slave group (e.g. 4 × 4-bit-address/8-bit-data slaves).

## Interface
- NUM_SLAVES, 4: number of attached slaves (1..2^SEL_W)
- SEL_W, 2: slave-select bits (upper part of req_addr)
- ADDR_W, 4: slave-local address width
- DATA_W, 8: data width
- RD_LAT, 1: cycles from rd_en strobe to valid slave read_data (0..7)

Ports (one clock; reset is asynchronous and active-high):
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  SEL_W+ADDR_W  {select, local address}
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_W  read data (0 for writes and errors)
- rsp_err  out  1  select index ≥ NUM_SLAVES
- io_wr_en  out  NUM_SLAVES  per-slave write strobe
- io_rd_en  out  NUM_SLAVES  per-slave read strobe
- io_address  out  ADDR_W  shared local address
- io_write_data  out  DATA_W  shared write data
- io_read_data  in  NUM_SLAVES*DATA_W  slave k at bits [k*DATA_W +: DATA_W]

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid: latch write, select, local address, wdata; go to ISSUE.
- ISSUE, exactly one cycle: if select < NUM_SLAVES, assert io_wr_en[sel] (write) or io_rd_en[sel] (read); otherwise no strobe and set err.
  - Write: go to RESP, or IDLE when CFG_BUS_MASTER_WR_RSP_EN is undefined.
  - Read: RD_LAT=0 samples io_read_data[sel] in this cycle and goes to RESP. RD_LAT>0 loads a counter and goes to WAIT.
- WAIT: decrement the counter. On the RD_LAT-th cycle after ISSUE, sample io_read_data[sel] and go to RESP.
- Error reads follow identical timing, with rdata forced to 0.
- RESP: rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready. On handshake, go to IDLE.
- io_address and io_write_data are registered from the latch and hold their last value between requests. At most one strobe bit is high in any cycle.
- Strobes are decoded from the state register and latched select only (glitch-free, no dependence on req_* inputs).
- Reset, including mid-transaction: state → IDLE and all latches cleared. A pending request is dropped with no response.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, io_wr_en=0, io_rd_en=0, io_address=0, io_write_data=0.
- Request accepted at edge T. Strobe is high in cycle T+1. Read data is sampled in cycle T+1+RD_LAT. rsp_valid rises at T+2+RD_LAT (write: T+2).
- Back-to-back: the next request is accepted on the edge after the RESP handshake. Minimum period is 3+RD_LAT cycles for reads and 3 for writes (2 without the write response).
- req_ready is 0 in ISSUE, WAIT and RESP. Requests presented then are not consumed.
- rsp_valid, once high, stays high with stable data until rsp_ready is sampled high.

## Configuration
- CFG_BUS_MASTER_WR_RSP_EN defined: writes produce a response (rsp_valid, rdata=0, err per select) and wait for rsp_ready.
- Undefined: writes return ISSUE→IDLE with no response and errored writes are silently discarded. Reads are unchanged.

## Test plan
- Reset release: all outputs at reset values and req_ready=1. Reset asserted during WAIT → next cycle IDLE, no rsp_valid, no strobe.
- Write, addr=0x25, wdata=0xA5: one cycle of io_wr_en=4'b0100, io_address=5, io_write_data=0xA5. With the macro, rsp_valid at T+2 with rdata=0, err=0.
- Read, addr=0x13, RD_LAT=1, slave1 returns 0x3C in the sample cycle: io_rd_en=4'b0010 for one cycle. rsp_valid at T+3 with rdata=0x3C, err=0.
- RD_LAT=0 and RD_LAT=3 builds: rsp_valid at T+2 and T+5 respectively, and data matches the value present in the sample cycle.
- NUM_SLAVES=3, read addr=0x3F: no strobe bit toggles; rsp_err=1, rdata=0 at T+3.
- rsp_ready held low 5 cycles, with a second req_valid held high: rsp fields stable, req_ready=0, second request accepted the cycle after the handshake.
